// File: rtl/mem_msg_pkg.sv
// Shared field layout and type codes for the 16-byte memory request/response messages.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_msg_pkg;

    // Message widths
    localparam int MEM_REQ_W  = 175;
    localparam int MEM_RESP_W = 145;

    // Field widths
    localparam int MEM_TYPE_W   = 3;
    localparam int MEM_OPAQUE_W = 8;
    localparam int MEM_ADDR_W   = 32;
    localparam int MEM_LEN_W    = 4;
    localparam int MEM_TEST_W   = 2;
    localparam int MEM_DATA_W   = 128;

    // Request field offsets (LSB of each field)
    localparam int REQ_DATA_LSB   = 0;
    localparam int REQ_LEN_LSB    = 128;
    localparam int REQ_ADDR_LSB   = 132;
    localparam int REQ_OPAQUE_LSB = 164;
    localparam int REQ_TYPE_LSB   = 172;

    // Response field offsets (LSB of each field)
    localparam int RESP_DATA_LSB   = 0;
    localparam int RESP_LEN_LSB    = 128;
    localparam int RESP_TEST_LSB   = 132;
    localparam int RESP_OPAQUE_LSB = 134;
    localparam int RESP_TYPE_LSB   = 142;

    // Request type codes
    localparam logic [MEM_TYPE_W-1:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [MEM_TYPE_W-1:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [MEM_TYPE_W-1:0] MEM_TYPE_WRITE_INIT = 3'd2;

    // Packed views; field order matches the offsets above (type at the MSB end)
    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_req_16b_t;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_TEST_W-1:0]   test;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_resp_16b_t;

    // Both write flavours touch the array identically
    function automatic logic is_write_type(input logic [MEM_TYPE_W-1:0] t);
        return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_WRITE_INIT);
    endfunction

endpackage

// File: rtl/mem_resp_delay_queue.sv
// In-order response FIFO where every entry ages LATENCY cycles before it may leave.
// Latency: entry pushed at edge n is presentable in cycle n+LATENCY (countdown from LATENCY-1).
// Backpressure: head held while pop_i is low; push ignored when full, even if popping that cycle.
module mem_resp_delay_queue #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int MSG_W   = 145
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [MSG_W-1:0] push_msg_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             head_ready_o,
    output logic [MSG_W-1:0] head_msg_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];
    logic [MSG_W-1:0] msg_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o       = (occ_q == OCC_W'(DEPTH));
    assign head_ready_o = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
    assign head_msg_o   = msg_q[rd_ptr_q];

    // Full blocks a push outright; a pop in the same cycle does not free the slot early
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && head_ready_o;

    // Next pointers, occupancy and per-slot countdowns
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        occ_d    = occ_q;
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push_ok && pop_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end
        // Every slot counts down independently; idle slots saturate at zero harmlessly,
        // so a stalled head never stops younger entries from aging.
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (push_ok && (wr_ptr_q == PTR_W'(i))) begin
                cnt_d[i] = CNT_LOAD;
            end
        end
    end

    // Control state register; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Payload storage; contents only matter while occupancy covers the slot
    always_ff @(posedge clk) begin
        if (push_ok) begin
            msg_q[wr_ptr_q] <= push_msg_i;
        end
    end

endmodule

// File: rtl/mem_16b_latency_responder.sv
// Memory-side responder: 128-bit line array answering 16B mem requests in order.
// Latency: response earliest LATENCY cycles after accept, one per cycle when streaming.
// Backpressure: resp_rdy low holds resp_msg; req_rdy drops once QUEUE_DEPTH requests are outstanding.
module mem_16b_latency_responder
    import mem_msg_pkg::*;
#(
    parameter int NUM_LINES   = 256,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MEM_REQ_W-1:0]  req_msg,
    input  logic                  req_val,
    output logic                  req_rdy,
    output logic [MEM_RESP_W-1:0] resp_msg,
    output logic                  resp_val,
    input  logic                  resp_rdy
);

    localparam int LINE_W = $clog2(NUM_LINES);

    mem_req_16b_t              req;
    mem_resp_16b_t             resp_in;
    logic [LINE_W-1:0]         line_idx;
    logic [3:0]                off;
    logic [MEM_ADDR_W-1:0]     req_addr;
    logic                      unused_addr_bits;
    logic                      push;
    logic                      q_full;
    logic                      q_head_ready;
    logic [MEM_RESP_W-1:0]     q_head_msg;
    logic [MEM_DATA_W-1:0]     wmask;
    logic [MEM_DATA_W-1:0]     wdata;
    logic [3:0]                rel;
    logic [3:0]                bidx;
    logic [MEM_DATA_W-1:0]     mem_q [NUM_LINES];

    assign req      = mem_req_16b_t'(req_msg);
    assign req_addr = req.addr;
    assign line_idx = req_addr[4 +: LINE_W];
    assign off      = req_addr[3:0];

    // Address bits above the line index alias onto the same lines
    assign unused_addr_bits = ^req_addr[MEM_ADDR_W-1:4+LINE_W];

    // Acceptance depends only on registered occupancy (and reset), never on resp_rdy
    assign req_rdy = !reset && !q_full;
    assign push    = req_val && req_rdy;

    // Byte-enable mask and aligned write data for the accepted write
    always_comb begin
        wmask = '0;
        wdata = '0;
        rel   = '0;
        bidx  = '0;
        if (req.len == '0) begin
            wmask = '1;
            wdata = req.data;
        end else begin
            // Bytes [off, off+len-1] take request bytes [0, len-1]; anything past byte 15 is dropped
            for (int b = 0; b < 16; b++) begin
                bidx = 4'(b);
                if (bidx >= off) begin
                    rel = bidx - off;
                    if (rel < req.len) begin
                        wmask[{bidx, 3'b000} +: 8] = 8'hFF;
                        wdata[{bidx, 3'b000} +: 8] = req.data[{rel, 3'b000} +: 8];
                    end
                end
            end
        end
    end

    // Response payload is formed at accept time, so a read sees the array as of that edge
    always_comb begin
        resp_in          = '0;
        resp_in.msg_type = req.msg_type;
        resp_in.opaque   = req.opaque;
        resp_in.test     = '0;
        resp_in.len      = req.len;
        if (req.msg_type == MEM_TYPE_READ) begin
            resp_in.data = mem_q[line_idx];
        end
    end

    // Backing array: not reset, written at the accepting edge so the next cycle's read sees it
    always_ff @(posedge clk) begin
        if (push && is_write_type(req.msg_type)) begin
            mem_q[line_idx] <= (mem_q[line_idx] & ~wmask) | (wdata & wmask);
        end
    end

    mem_resp_delay_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .LATENCY (LATENCY),
        .MSG_W   (MEM_RESP_W)
    ) u_delay_q (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_msg_i   (resp_in),
        .pop_i        (resp_rdy),
        .full_o       (q_full),
        .head_ready_o (q_head_ready),
        .head_msg_o   (q_head_msg)
    );

    // Reset squashes a ready head immediately; message reads zero whenever nothing is offered
    assign resp_val = q_head_ready && !reset;
    assign resp_msg = resp_val ? q_head_msg : '0;

endmodule

// File: tb/tb_mem_16b_latency_responder.sv
module tb_mem_16b_latency_responder;

    localparam logic [2:0] T_RD  = 3'd0;
    localparam logic [2:0] T_WR  = 3'd1;
    localparam logic [2:0] T_WRI = 3'd2;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1P = 128'hCCDD456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2  = 128'hDEADBEEFCAFEF00D1122334455667788;
    localparam logic [127:0] L5  = 128'hAABBCC0000;
    localparam logic [127:0] D5  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset;
    logic [174:0] req_msg;
    logic         req_val;
    logic         req_rdy;
    logic [144:0] resp_msg;
    logic         resp_val;
    logic         resp_rdy;

    int checks   = 0;
    int failures = 0;

    mem_16b_latency_responder dut (
        .clk      (clk),
        .reset    (reset),
        .req_msg  (req_msg),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .resp_msg (resp_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [174:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                            input logic [31:0] a, input logic [3:0] l,
                                            input logic [127:0] d);
        return {t, op, a, l, d};
    endfunction

    function automatic logic [144:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                             input logic [3:0] l, input logic [127:0] d);
        return {t, op, 2'b00, l, d};
    endfunction

    // Expected data for the backpressure burst: even opaques read line 4, odd read line 5
    function automatic logic [144:0] burst_resp(input int i);
        return mk_resp(T_RD, 8'(i), 4'd0, (i % 2 == 1) ? L5 : D2);
    endfunction

    task automatic chk(input string tag, input logic [174:0] got, input logic [174:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One request, then its response exactly LATENCY=2 cycles later, popped with resp_rdy=1
    task automatic txn(input string tag, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] a, input logic [3:0] l, input logic [127:0] d,
                       input logic [127:0] exp_data);
        req_msg = mk_req(t, op, a, l, d);
        req_val = 1'b1;
        @(negedge clk);
        chk({tag, "/rdy"}, req_rdy, 1'b1);
        next_cycle();
        req_val = 1'b0;
        req_msg = '0;
        @(negedge clk);
        chk({tag, "/early"}, resp_val, 1'b0);
        next_cycle();
        @(negedge clk);
        chk({tag, "/val"}, resp_val, 1'b1);
        chk({tag, "/msg"}, resp_msg, mk_resp(t, op, l, exp_data));
        next_cycle();
    endtask

    initial begin
        reset    = 1'b1;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;

        // Reset held for three cycles: nothing offered, nothing accepted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst/resp_val", resp_val, 1'b0);
            chk("rst/req_rdy", req_rdy, 1'b0);
            chk("rst/resp_msg", resp_msg, '0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst/req_rdy", req_rdy, 1'b1);
        chk("post_rst/resp_val", resp_val, 1'b0);
        next_cycle();

        // Full-line write then read back
        txn("wr_full", T_WR, 8'h01, 32'h40, 4'd0, D1, '0);
        txn("rd_full", T_RD, 8'h05, 32'h40, 4'd0, '0, D1);

        // Partial write at offset 14, len 4: only bytes 14,15 land
        txn("wr_part", T_WR, 8'h02, 32'h4E, 4'd4, 128'hAABBCCDD, '0);
        txn("rd_part", T_RD, 8'h03, 32'h40, 4'd0, '0, D1P);

        // Address wrap: 0x1040 aliases line 4
        txn("wr_wrap", T_WR, 8'h06, 32'h1040, 4'd0, D2, '0);
        txn("rd_wrap", T_RD, 8'h07, 32'h40, 4'd0, '0, D2);

        // Unknown type: echoed, zero data, array untouched
        txn("other_type", 3'd3, 8'h77, 32'h40, 4'd2, 128'hFFFF, '0);
        txn("rd_after_other", T_RD, 8'h78, 32'h40, 4'd0, '0, D2);

        // Mid-line partial write into a zeroed line (WRITE_INIT used for the clear)
        txn("wri_zero", T_WRI, 8'h30, 32'h50, 4'd0, '0, '0);
        txn("wr_mid", T_WR, 8'h31, 32'h52, 4'd3, 128'h00AABBCC, '0);
        txn("rd_mid", T_RD, 8'h32, 32'h50, 4'd0, '0, L5);

        // Backpressure: four accepts fill the queue, head held stable while stalled
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_msg = mk_req(T_RD, 8'(i), (i % 2 == 1) ? 32'h50 : 32'h40, 4'd0, '0);
            @(negedge clk);
            chk("fill/req_rdy", req_rdy, 1'b1);
            next_cycle();
        end
        req_msg = mk_req(T_RD, 8'd4, 32'h40, 4'd0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full/req_rdy", req_rdy, 1'b0);
            chk("stall/resp_val", resp_val, 1'b1);
            chk("stall/resp_msg", resp_msg, burst_resp(0));
            next_cycle();
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("drain0/req_rdy", req_rdy, 1'b0);
        chk("drain0/resp_val", resp_val, 1'b1);
        chk("drain0/resp_msg", resp_msg, burst_resp(0));
        next_cycle();
        @(negedge clk);
        chk("drain1/req_rdy", req_rdy, 1'b1);
        chk("drain1/resp_msg", resp_msg, burst_resp(1));
        next_cycle();
        req_msg = mk_req(T_RD, 8'd5, 32'h50, 4'd0, '0);
        @(negedge clk);
        chk("drain2/req_rdy", req_rdy, 1'b1);
        chk("drain2/resp_msg", resp_msg, burst_resp(2));
        next_cycle();
        req_val = 1'b0;
        req_msg = '0;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            chk("drain/resp_val", resp_val, 1'b1);
            chk("drain/resp_msg", resp_msg, burst_resp(i));
            next_cycle();
        end
        @(negedge clk);
        chk("drained/resp_val", resp_val, 1'b0);
        next_cycle();

        // Reset with three requests in flight
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_msg  = mk_req(T_WR, 8'h10, 32'h70, 4'd0, D5);
        next_cycle();
        req_msg  = mk_req(T_RD, 8'h11, 32'h40, 4'd0, '0);
        next_cycle();
        req_msg  = mk_req(T_RD, 8'h12, 32'h40, 4'd0, '0);
        @(negedge clk);
        chk("inflight/resp_val", resp_val, 1'b1);
        chk("inflight/resp_msg", resp_msg, mk_resp(T_WR, 8'h10, 4'd0, '0));
        next_cycle();
        req_val = 1'b0;
        req_msg = '0;
        reset   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst/resp_val", resp_val, 1'b0);
            chk("mid_rst/req_rdy", req_rdy, 1'b0);
            next_cycle();
        end
        reset    = 1'b0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_rst/resp_val", resp_val, 1'b0);
            chk("after_rst/req_rdy", req_rdy, 1'b1);
            next_cycle();
        end
        txn("rd_persist", T_RD, 8'h13, 32'h70, 4'd0, '0, D5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
